// File: rtl/alu_pkg.sv
// alu_pkg: opcode enum, request struct and skid-buffer state shared by the ALU operand stage.
package alu_pkg;
  typedef enum logic [3:0] {ADD, SUB, AND, OR, XOR, SHL, SHR, ROL, ROR} alu_op_e;
  localparam int NUM_OPS = 9;
  localparam int ALU_N = 8;
  // Default-width request; the stage builds an N-wide equivalent with the same field order.
  typedef struct packed {
    alu_op_e op;
    logic [ALU_N-1:0] a;
    logic [ALU_N-1:0] b;
    logic [$clog2(ALU_N)-1:0] amt;
    logic illegal;
  } alu_req_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;
endpackage

// File: rtl/alu_skid_buffer.sv
// alu_skid_buffer: generic two-entry skid buffer with registered in_ready and out_valid.
module alu_skid_buffer import alu_pkg::*; #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  skid_state_e state, state_nxt;
  T skid;
  logic in_hs, out_hs;
  assign in_hs = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  always_comb
    state_nxt = state == EMPTY ? (in_hs ? ONE : EMPTY) :
                state == ONE   ? (in_hs && !out_hs ? TWO : !in_hs && out_hs ? EMPTY : ONE) :
                                 (out_hs ? ONE : TWO);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      skid <= '0;
    end else begin
      state <= state_nxt;
      in_ready <= state_nxt != TWO;
      out_valid <= state_nxt != EMPTY;
      if (in_hs && (state == EMPTY || out_hs))
        out_data <= in_data;
      else if (state == TWO && out_hs)
        out_data <= skid;
      if (in_hs && state == ONE && !out_hs)
        skid <= in_data;
    end
  end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered issue stage presenting opcode, operands, shift amount and illegal flag.
module alu_operand_stage import alu_pkg::*; #(
  parameter int N = 8,
  parameter int OP_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_op,
  input  logic [N-1:0]         in_a,
  input  logic [N-1:0]         in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_W-1:0]      out_op,
  output logic [N-1:0]         out_a,
  output logic [N-1:0]         out_b,
  output logic [$clog2(N)-1:0] out_amt,
  output logic                 out_illegal,
  output logic [CNT_W-1:0]     issued_cnt
);
  localparam int AW = $clog2(N);
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [AW-1:0] amt;
    logic illegal;
  } req_t;
  req_t in_req, out_req;
  // N is a power of two, so b mod N is just the low bits.
  assign in_req = '{op: in_op, a: in_a, b: in_b, amt: in_b[AW-1:0],
                    illegal: int'({1'b0, in_op}) >= NUM_OPS};
  alu_skid_buffer #(.T(req_t)) u_skid (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_req),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_req)
  );
  assign out_op = out_req.op;
  assign out_a = out_req.a;
  assign out_b = out_req.b;
  assign out_amt = out_req.amt;
  assign out_illegal = out_req.illegal;
  always_ff @(posedge clk)
    if (rst)
      issued_cnt <= '0;
    else if (out_valid && out_ready)
      issued_cnt <= issued_cnt + 1'b1;
endmodule
